// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential PC generation, one-outstanding memory
// handshake and a small PC/instruction FIFO feeding decode, flushed on redirect.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);
    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [31:0] START_PC = RESET_PC & ~32'h3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SQUASH} state_e;

    state_e        state_q;
    logic          mem_req_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   fetch_pc_q;
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic        pop, ack, push, room;
    logic [31:0] redir_pc, pc_inc;

    assign pop      = (count_q != '0) && out_ready;
    assign ack      = mem_req_q && mem_ack;
    assign push     = (state_q == S_WAIT) && ack && !redirect;
    assign redir_pc = redirect_pc & ~32'h3;
    assign pc_inc   = fetch_pc_q + 32'd4;
    assign count_d  = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    // Only issue when the response is guaranteed a slot after this edge.
    assign room     = count_d < CW'(DEPTH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= START_PC;
            fetch_pc_q <= START_PC;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (redirect) begin
                        fetch_pc_q <= redir_pc;
                    end else if (room) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        fetch_pc_q <= redir_pc;
                        if (ack) begin
                            mem_req_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            state_q   <= S_SQUASH;
                        end
                    end else if (ack) begin
                        fetch_pc_q <= pc_inc;
                        if (room) begin
                            mem_addr_q <= pc_inc;
                        end else begin
                            mem_req_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end
                end
                S_SQUASH: begin
                    // Wrong-path request still in flight: wait out its ack, drop the data.
                    if (redirect) begin
                        fetch_pc_q <= redir_pc;
                        if (ack) begin
                            mem_req_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end else if (ack) begin
                        if (room) begin
                            mem_addr_q <= fetch_pc_q;
                            state_q    <= S_WAIT;
                        end else begin
                            mem_req_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (redirect) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (push) begin
                    pc_mem_q[tail_q]    <= fetch_pc_q;
                    instr_mem_q[tail_q] <= mem_rdata;
                    tail_q              <= tail_q + PW'(1);
                end
                if (pop) head_q <= head_q + PW'(1);
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = (count_q != '0);
    assign out_instr = instr_mem_q[head_q];
    assign out_pc    = pc_mem_q[head_q];
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed and random stimulus for ifetch_queue; an in-order PC scoreboard plus a
// latency-configurable memory model check every handoff and the req/addr protocol.
module tb_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req, mem_ack, out_valid;
    logic [31:0] mem_addr, mem_rdata, out_instr, out_pc;
    logic        out_ready = 1'b0;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: acks once a request has waited `lat` cycles (0 = same cycle).
    int lat = 0;
    int wcnt = 0;
    assign mem_ack   = mem_req && (wcnt >= lat);
    assign mem_rdata = mem_ack ? word(mem_addr) : 32'hDEAD_BEEF;
    always @(posedge clock or negedge reset) begin
        if (!reset) wcnt <= 0;
        else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    int          checks = 0, errors = 0;
    int          pops = 0, acks = 0, cur_len = 0, last_len = 0, since_redir = 2;
    logic [31:0] exp_pc = RESET_PC;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample just before the edge, then advance past it.
    task automatic tick();
        @(negedge clock);
        if (reset) begin
            if (since_redir < 2) chk("quiet_after_redirect", out_valid, 0);
            if (prev_pend) begin
                chk("req_held", mem_req, 1);
                chk("addr_stable", mem_addr, prev_addr);
            end
            if (out_valid && out_ready) begin
                chk("out_pc", out_pc, exp_pc);
                chk("out_instr", out_instr, word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (mem_req && mem_ack) begin
                acks++;
                last_len = cur_len + 1;
                cur_len = 0;
            end else if (mem_req) begin
                cur_len++;
            end
            prev_pend = mem_req && !mem_ack;
            prev_addr = mem_addr;
            if (redirect) exp_pc = redirect_pc & ~32'h3;
        end
        @(posedge clock);
        #1;
        since_redir = redirect ? 0 : (since_redir < 2 ? since_redir + 1 : 2);
    endtask

    task automatic wait_pc(input logic [31:0] target, input int budget, input string tag);
        int n = 0;
        while (exp_pc !== target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, exp_pc, target);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_pc = pc;
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
    endtask

    initial begin
        int p0;
        logic found;
        #2 reset = 1'b0;
        #10 chk_reset_vals();
        @(posedge clock); #1;
        reset = 1'b1;

        // Zero-wait memory, consumer stalled: first request, first output, fill to DEPTH.
        tick();
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, RESET_PC);
        tick();
        chk("first_valid", out_valid, 1);
        repeat (8) tick();
        chk("stall_pushes", 32'(acks), DEPTH);
        chk("stall_req", mem_req, 0);
        chk("stall_valid", out_valid, 1);

        // Release consumer: one instruction per cycle, in order.
        out_ready = 1'b1;
        p0 = pops;
        repeat (20) tick();
        chk("throughput_1pc", 32'(pops - p0), 20);

        // Three-cycle memory: one instruction per three cycles.
        lat = 2;
        repeat (15) tick();
        p0 = pops;
        repeat (30) tick();
        chk("throughput_lat3", 32'(pops - p0), 10);
        chk("req_len_lat3", 32'(last_len), 3);

        // Redirect while a request to 0x10 is pending.
        do_redirect(32'h0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mem_req && mem_addr == 32'h10) found = 1'b1;
            else tick();
        end
        chk("found_req10", found, 1);
        do_redirect(32'h100);
        wait_pc(32'h108, 60, "redir_pending");

        // Redirect coincident with ack and pop; misaligned target.
        lat = 0;
        repeat (6) tick();
        chk("coincide_pre", {mem_ack, out_valid}, 2'b11);
        do_redirect(32'h203);
        wait_pc(32'h208, 20, "redir_ack_pop");

        // Redirect from idle with a full queue and a same-cycle pop.
        out_ready = 1'b0;
        repeat (8) tick();
        chk("full_idle_req", mem_req, 0);
        out_ready = 1'b1;
        do_redirect(32'h300);
        wait_pc(32'h30C, 20, "redir_idle");

        // PC wrap at the top of the address space.
        do_redirect(32'hFFFF_FFF8);
        wait_pc(32'h8, 20, "pc_wrap");

        // Random ready / latency / redirects.
        for (int i = 0; i < 500; i++) begin
            out_ready   = ($urandom_range(0, 3) != 0);
            lat         = $urandom_range(0, 3);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom & 32'h0000_FFFF;
            tick();
        end
        redirect = 1'b0;
        out_ready = 1'b1;
        lat = 0;
        wait_pc(exp_pc + 32'd16, 60, "random_drain");

        // Reset asserted mid-request with queued data.
        out_ready = 1'b0;
        lat = 6;
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        tick();
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_req", mem_req, 1);
        #2 reset = 1'b0;
        prev_pend = 1'b0;
        cur_len = 0;
        #1 chk_reset_vals();
        exp_pc = RESET_PC;
        lat = 0;
        @(posedge clock); #1;
        reset = 1'b1;
        tick();
        chk("restart_req", mem_req, 1);
        chk("restart_addr", mem_addr, RESET_PC);
        out_ready = 1'b1;
        wait_pc(RESET_PC + 32'd16, 20, "restart_flow");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
